// File: rtl/aes_job_scheduler.sv
// Two-requester front end for a single 128-bit encryptor core: round-robin job
// acceptance, load pulse, done wait with blanking and timeout, tagged response.
module aes_job_scheduler #(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_plaintext,
    input  logic [DATA_W-1:0] req0_key,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_plaintext,
    input  logic [DATA_W-1:0] req1_key,
    output logic              req1_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_id,
    output logic              resp_error,
    output logic [DATA_W-1:0] enc_plaintext,
    output logic [DATA_W-1:0] enc_key,
    output logic              enc_load,
    input  logic [DATA_W-1:0] enc_ciphertext,
    input  logic              enc_done,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              id_q, id_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] pt_q, pt_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_id;
    logic              any_valid;

    // Under contention the requester that did not win last time goes next.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~rr_last_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        id_d       = id_q;
        err_d      = err_q;
        pt_d       = pt_q;
        key_d      = key_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        enc_load   = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = req0_valid & ~grant_id;
                req1_ready = req1_valid & grant_id;
                if (any_valid) begin
                    pt_d      = grant_id ? req1_plaintext : req0_plaintext;
                    key_d     = grant_id ? req1_key : req0_key;
                    id_d      = grant_id;
                    rr_last_d = grant_id;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                enc_load = 1'b1;
                cnt_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // First WAIT cycle is blanked: done may still be left over from the previous job.
                if ((cnt_q != '0) && enc_done) begin
                    data_d  = enc_ciphertext;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            id_q      <= 1'b0;
            err_q     <= 1'b0;
            pt_q      <= '0;
            key_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            id_q      <= id_d;
            err_q     <= err_d;
            pt_q      <= pt_d;
            key_q     <= key_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign enc_plaintext = pt_q;
    assign enc_key       = key_q;
    assign resp_data     = data_q;
    assign resp_id       = id_q;
    assign resp_error    = err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Bench for aes_job_scheduler: behavioural encryptor stub plus a scoreboard of
// expected responses filled at job acceptance and drained at the response handshake.
module tb_aes_job_scheduler;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic [DATA_W-1:0] req0_plaintext, req0_key, req1_plaintext, req1_key;
    logic              req0_ready, req1_ready;
    logic              resp_valid, resp_ready, resp_id, resp_error;
    logic [DATA_W-1:0] resp_data;
    logic [DATA_W-1:0] enc_plaintext, enc_key;
    logic              enc_load;
    logic [DATA_W-1:0] enc_ciphertext = '0;
    logic              enc_done = 1'b0;
    logic              busy;

    always #5 clk = ~clk;

    aes_job_scheduler #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_plaintext(req0_plaintext), .req0_key(req0_key), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_plaintext(req1_plaintext), .req1_key(req1_key), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_error(resp_error),
        .enc_plaintext(enc_plaintext), .enc_key(enc_key), .enc_load(enc_load),
        .enc_ciphertext(enc_ciphertext), .enc_done(enc_done), .busy(busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] enc_model(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] k);
        return {p[63:0], p[127:64]} ^ (k * 128'd3) ^ 128'hA5A5_0F0F_3C3C_9696_5A5A_F0F0_C3C3_6969;
    endfunction

    // Encryptor stub: done rises stub_delay cycles after the load pulse and stays
    // high until the next load; stub_delay=0 never completes. With stub_stale set
    // the previous done is left high for one extra cycle after the load.
    int stub_delay = 3;
    bit stub_stale = 1'b0;
    int dcnt = 0;
    bit stale_hold = 1'b0;

    always @(posedge clk) begin
        if (enc_load) begin
            dcnt       <= stub_delay - 1;
            stale_hold <= stub_stale;
            if (!stub_stale) enc_done <= 1'b0;
        end else begin
            if (stale_hold) begin
                enc_done   <= 1'b0;
                stale_hold <= 1'b0;
            end
            if (dcnt > 1) begin
                dcnt <= dcnt - 1;
            end else if (dcnt == 1) begin
                dcnt           <= 0;
                enc_done       <= 1'b1;
                enc_ciphertext <= enc_model(enc_plaintext, enc_key);
            end
        end
    end

    typedef struct packed {
        logic              id;
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   load_cyc = -1;
    int   resp_start = -1;
    logic prev_rv = 1'b0;
    bit   exp_timeout = 1'b0;
    logic model_rr = 1'b1;

    // Monitor: runs once per cycle just after the inputs for that cycle are driven.
    always begin
        exp_t e;
        logic gid, gexp;
        @(negedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_rr = 1'b1;
        end else begin
            if (req0_ready && req1_ready) chk("both_ready", 1, 0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                gid  = req1_valid && req1_ready;
                gexp = (req0_valid && req1_valid) ? ~model_rr : req1_valid;
                chk("grant_id", gid, gexp);
                model_rr = gid;
                e.id   = gid;
                e.err  = exp_timeout;
                e.data = exp_timeout ? '0 : (gid ? enc_model(req1_plaintext, req1_key)
                                                 : enc_model(req0_plaintext, req0_key));
                sb.push_back(e);
            end
            if (enc_load) load_cyc = cyc;
            if (resp_valid && !prev_rv) resp_start = cyc;
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", resp_id, e.id);
                    chk("resp_error", resp_error, e.err);
                    chk("resp_data", resp_data, e.data);
                end
            end
        end
        prev_rv = resp_valid;
    end

    task automatic wait_accept(input bit which, input int budget);
        int n = 0;
        #2;
        while (!(which ? req1_ready : req0_ready) && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("accept_wait", n < budget, 1);
    endtask

    task automatic wait_resp(input int budget);
        int n = 0;
        while (!resp_valid && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("resp_wait", n < budget, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_wait", n < budget, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        rst = 1'b1;
        req0_valid = 1'b0; req0_plaintext = '0; req0_key = '0;
        req1_valid = 1'b0; req1_plaintext = '0; req1_key = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_enc_load", enc_load, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_error", resp_error, 0);
        chk("rst_enc_pt", enc_plaintext, 0);
        chk("rst_enc_key", enc_key, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);

        // Contention from reset: req0, req1, then a lone req0, then req1 wins.
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_plaintext = 128'd1407; req0_key = 128'd25;
        req1_valid = 1'b1; req1_plaintext = 128'd285;  req1_key = 128'd1293;
        wait_accept(0, 5);
        chk("cont1_r1_blocked", req1_ready, 0);
        @(negedge clk);
        wait_accept(1, 20);
        chk("cont1_r0_blocked", req0_ready, 0);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_accept(0, 20);
        @(negedge clk);
        req1_valid = 1'b1;
        wait_accept(1, 20);
        chk("cont2_r0_blocked", req0_ready, 0);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_accept(0, 20);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_idle(100);

        // Single job with latency and load-pulse checks.
        req0_valid = 1'b1; req0_plaintext = 128'd1407; req0_key = 128'd25;
        wait_accept(0, 5);
        t0 = cyc;
        @(negedge clk);
        req0_valid = 1'b0;
        #2;
        chk("load_pulse", enc_load, 1);
        chk("ready_one_cycle", req0_ready, 0);
        @(negedge clk);
        #2;
        chk("load_once", enc_load, 0);
        wait_resp(20);
        chk("single_latency", cyc - t0, 5);
        wait_idle(20);

        // Stale done held into the first WAIT cycle must be ignored.
        stub_stale = 1'b1; stub_delay = 4;
        @(negedge clk);
        req0_valid = 1'b1; req0_plaintext = 128'hDEAD_BEEF; req0_key = 128'd7;
        wait_accept(0, 5);
        t0 = cyc;
        @(negedge clk);
        req0_valid = 1'b0;
        wait_resp(20);
        chk("blank_latency", cyc - t0, 6);
        wait_idle(20);
        stub_stale = 1'b0;

        // Timeout: done never rises.
        stub_delay = 0; exp_timeout = 1'b1;
        @(negedge clk);
        req1_valid = 1'b1; req1_plaintext = 128'd285; req1_key = 128'd1293;
        wait_accept(1, 5);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_resp(TIMEOUT + 20);
        chk("timeout_latency", resp_start - load_cyc - 1, TIMEOUT);
        wait_idle(20);
        exp_timeout = 1'b0; stub_delay = 3;

        // Backpressure; request inputs change after acceptance.
        @(negedge clk);
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_plaintext = 128'h1234_5678; req0_key = 128'h42;
        wait_accept(0, 5);
        @(negedge clk);
        req0_plaintext = 128'hFFFF;
        #2;
        wait_resp(20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk("bp_valid", resp_valid, 1);
            chk("bp_data", resp_data, enc_model(128'h1234_5678, 128'h42));
            chk("bp_id", resp_id, 0);
            chk("bp_r0_ready", req0_ready, 0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #2;
        chk("hs_r0_ready", req0_ready, 0);
        @(negedge clk);
        #2;
        chk("post_hs_valid", resp_valid, 0);
        chk("post_hs_accept", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_idle(20);

        // Reset two cycles into WAIT drops the job.
        stub_delay = 10;
        @(negedge clk);
        req0_valid = 1'b1; req0_plaintext = 128'd77; req0_key = 128'd88;
        wait_accept(0, 5);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #2;
        chk("pre_rst_busy", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_load", enc_load, 0);
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_data", resp_data, 0);
        chk("mid_rst_pt", enc_plaintext, 0);
        repeat (15) @(negedge clk);
        stub_delay = 3;
        req1_valid = 1'b1; req1_plaintext = 128'd285; req1_key = 128'd1293;
        wait_accept(1, 5);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_idle(30);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
